// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//
// Command buffer and issue stage in front of the ALU. A producer pushes
// {op, operand A, operand B} commands over a valid/ready handshake into a
// DEPTH-entry FIFO. At most one command per cycle is popped onto the
// registered ALU-facing outputs. When the queue is empty, held or flushed,
// the op output is driven to NOP (0).
//
// Parameters
//   BITS      operand width (must match the ALU)
//   DEPTH     FIFO entries, power of 2, >= 2
//   CNT_BITS  width of the wrapping issued-command counter
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_valid / o_ready          producer handshake (o_ready = not full)
//   i_sel_op, i_op_a, i_op_b   command presented by the producer
//   i_hold                     stall: no pop this cycle
//   i_flush                    discard every queued command
//   o_sel_op, o_op_a, o_op_b   registered command to the ALU
//   o_issue                    outputs carry a command popped this cycle
//   o_count, o_empty, o_full   registered occupancy status
//   o_issued_cnt               wrapping count of issued commands
// ---------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int BITS     = 8,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [4:0]                 i_sel_op,
    input  logic [BITS-1:0]            i_op_a,
    input  logic [BITS-1:0]            i_op_b,
    input  logic                       i_hold,
    input  logic                       i_flush,
    output logic [4:0]                 o_sel_op,
    output logic [BITS-1:0]            o_op_a,
    output logic [BITS-1:0]            o_op_b,
    output logic                       o_issue,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [CNT_BITS-1:0]        o_issued_cnt
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CW       = PTR_BITS + 1;
    localparam int ENTRY_W  = 5 + 2 * BITS;

    // Entry layout: {op, a, b}
    logic [ENTRY_W-1:0]  mem [0:DEPTH-1];

    logic [PTR_BITS-1:0] wr_ptr_reg;
    logic [PTR_BITS-1:0] rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic [CW-1:0]       count_next;

    logic [4:0]          sel_op_reg;
    logic [BITS-1:0]     op_a_reg;
    logic [BITS-1:0]     op_b_reg;
    logic                issue_reg;
    logic [CNT_BITS-1:0] issued_cnt_reg;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;

    // Status decoded only from the registered count, so o_ready never
    // depends combinationally on this cycle's pop.
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Flush wins over a same-cycle push: the handshake completes from the
    // producer's side but the command is dropped.
    assign push = i_valid && !full && !i_flush;
    assign pop  = !i_hold && !empty && !i_flush;

    assign head = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array: no reset, write-only from the push side.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem[wr_ptr_reg] <= {i_sel_op, i_op_a, i_op_b};
        end
    end

    // Pointers and occupancy. Pointers wrap naturally since DEPTH is 2^N.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            end
            count_reg <= count_next;
        end
    end

    // Issue register. On idle cycles the operands are left untouched to
    // avoid needless toggling on the ALU inputs; only the op goes to NOP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_op_reg     <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            issue_reg      <= 1'b0;
            issued_cnt_reg <= '0;
        end else if (pop) begin
            sel_op_reg     <= head[ENTRY_W-1 -: 5];
            op_a_reg       <= head[2*BITS-1 -: BITS];
            op_b_reg       <= head[BITS-1:0];
            issue_reg      <= 1'b1;
            issued_cnt_reg <= issued_cnt_reg + CNT_BITS'(1);
        end else begin
            sel_op_reg     <= '0;
            issue_reg      <= 1'b0;
        end
    end

    assign o_ready      = !full;
    assign o_sel_op     = sel_op_reg;
    assign o_op_a       = op_a_reg;
    assign o_op_b       = op_b_reg;
    assign o_issue      = issue_reg;
    assign o_count      = count_reg;
    assign o_empty      = empty;
    assign o_full       = full;
    assign o_issued_cnt = issued_cnt_reg;

endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
//
// Self-checking bench for alu_issue_queue (BITS=8, DEPTH=4, CNT_BITS=4).
// A queue-based reference model tracks the expected outputs every cycle;
// a vector table holds hand-derived expectations for reset, single command
// and fill-under-hold; hand sequences cover streaming, flush, reset
// mid-stream and counter wrap; a random phase closes the run.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;

    localparam int BITS     = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_BITS = 4;

    logic                   i_clk;
    logic                   i_rst;
    logic                   i_valid;
    logic                   o_ready;
    logic [4:0]             i_sel_op;
    logic [BITS-1:0]        i_op_a;
    logic [BITS-1:0]        i_op_b;
    logic                   i_hold;
    logic                   i_flush;
    logic [4:0]             o_sel_op;
    logic [BITS-1:0]        o_op_a;
    logic [BITS-1:0]        o_op_b;
    logic                   o_issue;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_empty;
    logic                   o_full;
    logic [CNT_BITS-1:0]    o_issued_cnt;

    alu_issue_queue #(
        .BITS(BITS),
        .DEPTH(DEPTH),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_sel_op(i_sel_op),
        .i_op_a(i_op_a),
        .i_op_b(i_op_b),
        .i_hold(i_hold),
        .i_flush(i_flush),
        .o_sel_op(o_sel_op),
        .o_op_a(o_op_a),
        .o_op_b(o_op_b),
        .o_issue(o_issue),
        .o_count(o_count),
        .o_empty(o_empty),
        .o_full(o_full),
        .o_issued_cnt(o_issued_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t       mq[$];
    logic [4:0] m_sel   = '0;
    logic [7:0] m_a     = '0;
    logic [7:0] m_b     = '0;
    logic       m_issue = 1'b0;
    int         m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic rst, input logic valid, input logic hold,
                              input logic flush, input cmd_t c);
        bit   can_push;
        cmd_t h;
        can_push = (mq.size() < DEPTH);
        if (rst) begin
            mq.delete();
            m_sel = '0; m_a = '0; m_b = '0; m_issue = 1'b0; m_cnt = 0;
        end else if (flush) begin
            mq.delete();
            m_sel = '0; m_issue = 1'b0;
        end else begin
            if (!hold && mq.size() > 0) begin
                h = mq.pop_front();
                m_sel = h.op; m_a = h.a; m_b = h.b; m_issue = 1'b1;
                m_cnt = (m_cnt + 1) % (1 << CNT_BITS);
            end else begin
                m_sel = '0; m_issue = 1'b0;
            end
            if (valid && can_push) mq.push_back(c);
        end
    endtask

    // Apply one cycle of inputs, advance the model and the DUT, compare.
    task automatic do_cycle(input logic rst, input logic valid, input logic hold,
                            input logic flush, input logic [4:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        cmd_t c;
        int   n;
        i_rst = rst; i_valid = valid; i_hold = hold; i_flush = flush;
        i_sel_op = op; i_op_a = a; i_op_b = b;
        c.op = op; c.a = a; c.b = b;
        model_step(rst, valid, hold, flush, c);
        @(posedge i_clk);
        #1;
        cyc++;
        n = mq.size();
        if (o_issue)
            $display("cycle %0d issue op=%0h a=%0h b=%0h count=%0d issued=%0d",
                     cyc, o_sel_op, o_op_a, o_op_b, o_count, o_issued_cnt);
        chk("m_sel",   32'(o_sel_op), 32'(m_sel));
        chk("m_a",     32'(o_op_a), 32'(m_a));
        chk("m_b",     32'(o_op_b), 32'(m_b));
        chk("m_issue", 32'(o_issue), 32'(m_issue));
        chk("m_count", 32'(o_count), n);
        chk("m_empty", 32'(o_empty), 32'(n == 0));
        chk("m_full",  32'(o_full), 32'(n == DEPTH));
        chk("m_ready", 32'(o_ready), 32'(n != DEPTH));
        chk("m_cnt",   32'(o_issued_cnt), m_cnt);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       hold;
        logic       flush;
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] e_sel;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic       e_issue;
        logic [2:0] e_count;
        logic       e_ready;
        logic [3:0] e_cnt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_hold = 1'b0; i_flush = 1'b0;
        i_sel_op = '0; i_op_a = '0; i_op_b = '0;

        //          rst   vld   hold  fl    op     a      b       e_sel  e_a    e_b    iss  cnt   rdy  issued
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 8'h12, 8'h34,  5'd0, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd1, 8'h12, 8'h34, 1'b1, 3'd0, 1'b1, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd0, 8'h12, 8'h34, 1'b0, 3'd0, 1'b1, 4'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 8'h11, 8'h21,  5'd0, 8'h12, 8'h34, 1'b0, 3'd1, 1'b1, 4'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 8'h12, 8'h22,  5'd0, 8'h12, 8'h34, 1'b0, 3'd2, 1'b1, 4'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 8'h13, 8'h23,  5'd0, 8'h12, 8'h34, 1'b0, 3'd3, 1'b1, 4'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 8'h14, 8'h24,  5'd0, 8'h12, 8'h34, 1'b0, 3'd4, 1'b0, 4'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 8'h15, 8'h25,  5'd0, 8'h12, 8'h34, 1'b0, 3'd4, 1'b0, 4'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 8'h15, 8'h25,  5'd1, 8'h11, 8'h21, 1'b1, 3'd3, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 8'h15, 8'h25,  5'd2, 8'h12, 8'h22, 1'b1, 3'd3, 1'b1, 4'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd3, 8'h13, 8'h23, 1'b1, 3'd2, 1'b1, 4'd4};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd4, 8'h14, 8'h24, 1'b1, 3'd1, 1'b1, 4'd5};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd5, 8'h15, 8'h25, 1'b1, 3'd0, 1'b1, 4'd6};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00,  5'd0, 8'h15, 8'h25, 1'b0, 3'd0, 1'b1, 4'd6};

        // Reset, single command, fill under hold and in-order drain.
        for (int i = 0; i < NVEC; i++) begin
            do_cycle(vecs[i].rst, vecs[i].valid, vecs[i].hold, vecs[i].flush,
                     vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_sel", i),   32'(o_sel_op), 32'(vecs[i].e_sel));
            chk($sformatf("v%0d_a", i),     32'(o_op_a), 32'(vecs[i].e_a));
            chk($sformatf("v%0d_b", i),     32'(o_op_b), 32'(vecs[i].e_b));
            chk($sformatf("v%0d_issue", i), 32'(o_issue), 32'(vecs[i].e_issue));
            chk($sformatf("v%0d_count", i), 32'(o_count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_full", i),  32'(o_full), 32'(vecs[i].e_count == 3'd4));
            chk($sformatf("v%0d_empty", i), 32'(o_empty), 32'(vecs[i].e_count == 3'd0));
            chk($sformatf("v%0d_cnt", i),   32'(o_issued_cnt), 32'(vecs[i].e_cnt));
        end

        // Idle after reset stays quiet for 10 cycles.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
            chk("idle_issue", 32'(o_issue), 32'd0);
            chk("idle_sel", 32'(o_sel_op), 32'd0);
            chk("idle_cnt", 32'(o_issued_cnt), 32'd0);
        end

        // Steady streaming at occupancy 2.
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 8'hA0, 8'hB0);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 8'hA1, 8'hB1);
        chk("stream_pre_count", 32'(o_count), 32'd2);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'($urandom_range(1, 12)),
                     8'($urandom), 8'($urandom));
            chk("stream_count", 32'(o_count), 32'd2);
            chk("stream_issue", 32'(o_issue), 32'd1);
        end

        // Flush with a simultaneous push of op 7 while three entries are queued.
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 8'h33, 8'h44);
        chk("flush_pre_count", 32'(o_count), 32'd3);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 8'h77, 8'h77);
        chk("flush_count", 32'(o_count), 32'd0);
        chk("flush_issue", 32'(o_issue), 32'd0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
            chk("flush_after_issue", 32'(o_issue), 32'd0);
            chk("flush_after_sel", 32'(o_sel_op), 32'd0);
        end

        // Reset mid-stream at occupancy 3.
        for (int i = 0; i < 3; i++)
            do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'(i + 1), 8'(i), 8'(i));
        chk("rst_pre_count", 32'(o_count), 32'd3);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_cnt", 32'(o_issued_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
            chk("rst_after_issue", 32'(o_issue), 32'd0);
        end

        // 17 issues from reset wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++)
            do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'((i % 12) + 1), 8'(i), 8'(i + 8'h40));
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
        chk("wrap_cnt", 32'(o_issued_cnt), 32'd1);
        chk("wrap_empty", 32'(o_empty), 32'd1);

        // Random phase against the reference model.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 99) < 2),
                     1'($urandom_range(0, 99) < 60),
                     1'($urandom_range(0, 99) < 30),
                     1'($urandom_range(0, 99) < 5),
                     5'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Command buffer and issue stage that sits directly upstream of the ALU top and drives its i_sel_op, i_op_a and i_op_b inputs.
- Accepts {op, operand A, operand B} commands from a producer over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Issues one command per cycle to the ALU through registered outputs; when empty, held or flushed, it drives NOP.
- Provides occupancy status and a wrapping count of issued commands.

Parameters:
- BITS, 8, operand width; must match the ALU.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_BITS, 16, width of the issued-command counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  producer presents a command.
- o_ready  output  1  queue can accept a command (not full).
- i_sel_op  input  5  op code in ALU encoding (1..c = add..cpb; others = nop).
- i_op_a  input  BITS  operand A.
- i_op_b  input  BITS  operand B.
- i_hold  input  1  stall: no pop this cycle.
- i_flush  input  1  discard all queued commands.
- o_sel_op  output  5  registered op code to the ALU.
- o_op_a  output  BITS  registered operand A to the ALU.
- o_op_b  output  BITS  registered operand B to the ALU.
- o_issue  output  1  o_sel_op/o_op_a/o_op_b carry a popped command this cycle.
- o_count  output  $clog2(DEPTH)+1  current occupancy.
- o_empty  output  1  o_count == 0.
- o_full  output  1  o_count == DEPTH.
- o_issued_cnt  output  CNT_BITS  number of commands issued, wraps.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - FIFO pointers and count cleared.
  - o_sel_op=0, o_op_a=0, o_op_b=0, o_issue=0, o_issued_cnt=0.
  - Therefore o_ready=1, o_empty=1, o_full=0.
  - Reset mid-operation drops all entries; nothing is issued afterwards until a new push.
- Push: occurs when i_valid && o_ready.
  - o_ready = !o_full, decoded from registered count; no combinational path from pop.
  - While full, a push is refused even if a pop happens in the same cycle.
  - The producer must hold the command stable until accepted.
  - The op code is stored unmodified. Invalid codes are forwarded as-is and the ALU treats them as nop.
- Pop: occurs when !i_hold && !o_empty && !i_flush.
  - The head entry is registered onto o_sel_op/o_op_a/o_op_b at the edge, with o_issue=1.
  - o_issued_cnt increments by 1, wrapping at 2^CNT_BITS.
- No pop (empty, hold or flush):
  - Next cycle o_sel_op=0 (nop) and o_issue=0.
  - o_op_a/o_op_b keep their previous values, to limit toggling.
- Latency: a command pushed at edge t into an empty, un-held queue appears on the outputs after edge t+1. That is 2 cycles from i_valid to the ALU input; the ALU adds its own register stage.
- No fall-through: an entry pushed at edge t is visible to pop only from cycle t+1.
- Simultaneous push and pop with 0 < count < DEPTH: both happen and count is unchanged.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Flush:
  - Pointers and count cleared at the edge.
  - A push in the same cycle is discarded; flush has priority.
  - Next cycle outputs are nop with o_issue=0.
  - o_issued_cnt is not cleared.
- i_hold has no effect on push acceptance. Hold with flush gives flush behaviour.
- Status: o_count, o_empty and o_full are registered state, always mutually consistent, and update on the edge after each push/pop/flush.

Test Plan:
- Reset then idle:
  - Response: o_ready=1, o_empty=1, o_sel_op=0, o_issue=0, o_issued_cnt=0 for 10 cycles.
- Single command: push {op=1, a=8'h12, b=8'h34} at cycle 0.
  - Response: cycle 2 shows o_sel_op=1, o_op_a=12, o_op_b=34, o_issue=1.
  - Cycle 3 shows o_sel_op=0, o_op_a=12, o_issue=0; o_issued_cnt=1.
- Fill under hold: i_hold=1, push 5 commands ops 1..5.
  - Response: first 4 accepted, o_full=1, o_ready=0 and the 5th stalls.
  - Release hold: ops 1,2,3,4,5 issue in order on consecutive cycles and o_issued_cnt=5.
- Steady streaming: count=2, push and pop every cycle for 20 cycles.
  - Response: o_count stays 2 and issue order matches push order.
- Flush with push: queue holds 3 entries; assert i_flush and i_valid (op=7) together.
  - Response: next cycle o_count=0 and o_issue=0; op 7 is never issued.
- Reset mid-stream, then counter wrap (CNT_BITS=4):
  - Response: reset at count=3 empties the queue with no further issues.
  - Then 17 issues give o_issued_cnt=1.
